// File: rtl/crc_serial_if.sv
// Handshake, serial data and status bundle for crc_serial.
// The DUT side uses the slave modport; the driving side uses master.
interface crc_serial_if #(
  parameter int unsigned CRC_W = 5,
  parameter int unsigned LEN_W = 11
);
  logic             start;
  logic             mode;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             s_in;
  logic             abort;
  logic             s_out;
  logic             out_valid;
  logic             ready;
  logic             done;
  logic             crc_ok;
  logic [CRC_W-1:0] crc_value;

  modport master (
    output start, mode, len, in_valid, s_in, abort,
    input  s_out, out_valid, ready, done, crc_ok, crc_value
  );

  modport slave (
    input  start, mode, len, in_valid, s_in, abort,
    output s_out, out_valid, ready, done, crc_ok, crc_value
  );
endinterface

// File: rtl/crc_serial.sv
// Bit-serial CRC generator/checker: generate mode passes data through and
// appends the complemented remainder; check mode compares against a residue.
module crc_serial #(
  parameter int unsigned          CRC_W   = 5,
  parameter logic [CRC_W-1:0]     POLY    = CRC_W'(5'b00101),
  parameter logic [CRC_W-1:0]     RESIDUE = CRC_W'(5'b01100),
  parameter int unsigned          LEN_W   = 11
) (
  input logic         clk,
  input logic         rst_n,
  crc_serial_if.slave bus
);

  localparam int unsigned KW = $clog2(CRC_W);

  typedef enum logic [1:0] {IDLE, DATA, APPEND, DONE} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [KW-1:0]    k_q, k_d;
  logic             crc_ok_q, crc_ok_d;
  logic             fb;
  logic             app_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      crc_q    <= '1;
      cnt_q    <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      k_q      <= '0;
      crc_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      crc_ok_q <= crc_ok_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    mode_d   = mode_q;
    k_d      = k_q;
    crc_ok_d = crc_ok_q;
    fb       = crc_q[CRC_W-1] ^ bus.s_in;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          mode_d   = bus.mode;
          len_d    = bus.len;
          crc_d    = '1;
          cnt_d    = '0;
          k_d      = '0;
          crc_ok_d = 1'b0;
          if (bus.len == '0) state_d = bus.mode ? DONE : APPEND;
          else               state_d = DATA;
        end
      end
      DATA: begin
        if (bus.in_valid) begin
          crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = mode_q ? DONE : APPEND;
        end
      end
      APPEND: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(CRC_W - 1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Latch the verdict on entry to DONE so crc_ok is valid alongside done;
    // crc_d already includes the final data bit.
    if (state_d == DONE && state_q != DONE) crc_ok_d = mode_d && (crc_d == RESIDUE);

    if (bus.abort && state_q != IDLE) begin
      state_d  = IDLE;
      crc_d    = crc_q;
      cnt_d    = cnt_q;
      crc_ok_d = 1'b0;
    end
  end

  // Remainder bit for the current APPEND slot, MSB first.
  always_comb begin
    app_bit = 1'b0;
    for (int unsigned i = 0; i < CRC_W; i++) begin
      if (k_q == KW'(CRC_W - 1 - i)) app_bit = crc_q[i];
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.s_out     = 1'b0;
    if (state_q == DATA && !mode_q) begin
      bus.out_valid = bus.in_valid;
      bus.s_out     = bus.s_in;
    end else if (state_q == APPEND) begin
      bus.out_valid = 1'b1;
      bus.s_out     = ~app_bit;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.crc_ok    = crc_ok_q;
  assign bus.crc_value = crc_q;

endmodule

// File: tb/tb_crc_serial.sv
// Directed bench for crc_serial: CRC5 generate/check/abort/reset cases and a CRC16 zero-length run.
module tb_crc_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crc_serial_if #(.CRC_W(5),  .LEN_W(11)) if5 ();
  crc_serial_if #(.CRC_W(16), .LEN_W(11)) if16 ();

  crc_serial #(.CRC_W(5), .POLY(5'b00101), .RESIDUE(5'b01100), .LEN_W(11)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5.slave)
  );

  crc_serial #(.CRC_W(16), .POLY(16'h8005), .RESIDUE(16'h800D), .LEN_W(11)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle5();
    if5.start = 1'b0; if5.mode = 1'b0; if5.len = '0;
    if5.in_valid = 1'b0; if5.s_in = 1'b0; if5.abort = 1'b0;
  endtask

  task automatic check_reset5(input string tag);
    check({tag, "_ready"}, 32'(if5.ready), 1);
    check({tag, "_crc"},   32'(if5.crc_value), 32'h1f);
    check({tag, "_ov"},    32'(if5.out_valid), 0);
    check({tag, "_so"},    32'(if5.s_out), 0);
    check({tag, "_done"},  32'(if5.done), 0);
    check({tag, "_ok"},    32'(if5.crc_ok), 0);
  endtask

  // Enter at a negedge; leave at the negedge after start was accepted.
  task automatic start5(input logic m, input logic [10:0] l);
    if5.start = 1'b1; if5.mode = m; if5.len = l;
    #1 check("start_ready", 32'(if5.ready), 1);
    tick();
    if5.start = 1'b0;
  endtask

  task automatic bits5(input logic [15:0] bits, input int n, input logic m, input logic gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        if5.in_valid = 1'b0; if5.s_in = 1'b1;
        #1 check("gap_ov", 32'(if5.out_valid), 0);
        tick();
      end
      if5.in_valid = 1'b1; if5.s_in = bits[n-1-i];
      #1;
      check("pass_ov", 32'(if5.out_valid), m ? 0 : 1);
      check("pass_so", 32'(if5.s_out), m ? 0 : 32'(bits[n-1-i]));
      tick();
    end
    if5.in_valid = 1'b0; if5.s_in = 1'b0;
  endtask

  task automatic append5(input logic [4:0] want_bits);
    if5.in_valid = 1'b1; if5.s_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("app_ov", 32'(if5.out_valid), 1);
      check("app_so", 32'(if5.s_out), 32'(want_bits[4-k]));
      tick();
    end
    if5.in_valid = 1'b0; if5.s_in = 1'b0;
  endtask

  task automatic gen_run5();
    start5(1'b0, 11'd11);
    bits5(16'h0000, 11, 1'b0, 1'b0);
    #1 check("gen_crc", 32'(if5.crc_value), 32'b10111);
    append5(5'b01000);
    #1;
    check("gen_done", 32'(if5.done), 1);
    check("gen_done_ov", 32'(if5.out_valid), 0);
    check("gen_done_ok", 32'(if5.crc_ok), 0);
    tick();
    #1;
    check("gen_after_done", 32'(if5.done), 0);
    check("gen_after_ready", 32'(if5.ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle5();
    if16.start = 1'b0; if16.mode = 1'b0; if16.len = '0;
    if16.in_valid = 1'b0; if16.s_in = 1'b0; if16.abort = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    #1 check_reset5("rst");
    tick();
    rst_n = 1'b1;

    // Generate run started on the first edge after reset release.
    gen_run5();

    // Check mode, good packet.
    start5(1'b1, 11'd16);
    bits5(16'h0008, 16, 1'b1, 1'b0);
    #1;
    check("chk_crc", 32'(if5.crc_value), 32'b01100);
    check("chk_done", 32'(if5.done), 1);
    check("chk_ok", 32'(if5.crc_ok), 1);
    check("chk_ov", 32'(if5.out_valid), 0);
    tick();
    #1;
    check("chk_ok_held", 32'(if5.crc_ok), 1);
    check("chk_done_drop", 32'(if5.done), 0);

    // Check mode, bit 3 flipped, with gaps.
    start5(1'b1, 11'd16);
    #1 check("chk_ok_cleared", 32'(if5.crc_ok), 0);
    bits5(16'h1008, 16, 1'b1, 1'b1);
    #1;
    check("bad_done", 32'(if5.done), 1);
    check("bad_ok", 32'(if5.crc_ok), 0);
    tick();

    // start and abort together in IDLE: start ignored.
    if5.start = 1'b1; if5.abort = 1'b1;
    tick();
    if5.start = 1'b0; if5.abort = 1'b0;
    #1 check("sa_ready", 32'(if5.ready), 1);
    tick();

    // Abort mid-APPEND.
    start5(1'b0, 11'd11);
    bits5(16'h0000, 11, 1'b0, 1'b1);
    #1 check("ab_crc", 32'(if5.crc_value), 32'b10111);
    check("ab_so0", 32'(if5.s_out), 0);
    tick();
    #1 check("ab_so1", 32'(if5.s_out), 1);
    tick();
    if5.abort = 1'b1;
    tick();
    if5.abort = 1'b0;
    #1;
    check("ab_ready", 32'(if5.ready), 1);
    check("ab_ov", 32'(if5.out_valid), 0);
    check("ab_done", 32'(if5.done), 0);
    check("ab_ok", 32'(if5.crc_ok), 0);
    tick();
    #1 check("ab_no_late_done", 32'(if5.done), 0);
    gen_run5();

    // Reset mid-DATA with start held while busy.
    start5(1'b0, 11'd11);
    bits5(16'h0000, 4, 1'b0, 1'b0);
    #1 check("rd_crc4", 32'(if5.crc_value), 32'b00110);
    if5.start = 1'b1;
    bits5(16'h0000, 3, 1'b0, 1'b0);
    #1;
    check("rd_crc7", 32'(if5.crc_value), 32'b10101);
    check("rd_busy", 32'(if5.ready), 0);
    if5.in_valid = 1'b1; if5.s_in = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset5("rd");
    tick();
    idle5();
    rst_n = 1'b1;
    gen_run5();

    // CRC16 generate with zero length: straight to APPEND.
    if16.start = 1'b1; if16.mode = 1'b0; if16.len = '0;
    #1 check("c16_ready", 32'(if16.ready), 1);
    tick();
    if16.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("c16_ov", 32'(if16.out_valid), 1);
      check("c16_so", 32'(if16.s_out), 0);
      tick();
    end
    #1;
    check("c16_done", 32'(if16.done), 1);
    check("c16_crc", 32'(if16.crc_value), 32'hffff);
    tick();
    #1;
    check("c16_done_drop", 32'(if16.done), 0);
    check("c16_ready_end", 32'(if16.ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
